// File: rtl/dtype_pkg.sv
// Shared constants and helpers for fixed-latency retiming pipelines (dtype_pipe and friends).
package dtype_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dtype_stage.sv
// One delay-line stage: WIDTH data bits plus a valid bit, with advance enable and valid clear.
module dtype_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      // Data keeps following en during a clear; it is don't-care once invalid.
      if (en) q <= d;
      if (clear)   q_valid <= 1'b0;
      else if (en) q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dtype_pipe.sv
// Parametrised D-type delay line with advance enable and valid flush.
// Define DTYPE_PIPE_COUNT_EN to add the occupancy port and counter.
module dtype_pipe
  import dtype_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef DTYPE_PIPE_COUNT_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic [WIDTH-1:0] data [DEPTH];
  logic             vld  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dtype_stage #(.WIDTH(WIDTH)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .clear   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (data[i]),
        .q_valid (vld[i])
      );
    end else begin : g_body
      dtype_stage #(.WIDTH(WIDTH)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .clear   (flush),
        .d       (data[i-1]),
        .d_valid (vld[i-1]),
        .q       (data[i]),
        .q_valid (vld[i])
      );
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

`ifdef DTYPE_PIPE_COUNT_EN
  localparam int unsigned OW = occ_width(DEPTH);

  logic [OW-1:0] count;
  logic [OW-1:0] pop;

  // Modular add/subtract is exact here: the true result always lies in 0..DEPTH.
  always_ff @(posedge clock) begin
    if (reset || flush) count <= '0;
    else if (en)        count <= count + OW'(d_valid) - OW'(vld[DEPTH-1]);
  end

  assign occupancy = count;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DEPTH; i++) pop = pop + OW'(vld[i]);
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (count == pop);
  end
`endif

endmodule

// File: tb/tb_dtype_pipe.sv
// Directed bench for dtype_pipe: DEPTH=4 main instance plus a DEPTH=1 corner instance.
module tb_dtype_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;
  logic [7:0] q;
  logic       q_valid;
  logic [7:0] q1;
  logic       q1_valid;
`ifdef DTYPE_PIPE_COUNT_EN
  logic [2:0] occ;
  logic [0:0] occ1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dtype_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q),
    .q_valid   (q_valid)
`ifdef DTYPE_PIPE_COUNT_EN
    ,
    .occupancy (occ)
`endif
  );

  dtype_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q1),
    .q_valid   (q1_valid)
`ifdef DTYPE_PIPE_COUNT_EN
    ,
    .occupancy (occ1)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({q_valid, q} !== 9'h000) begin
      bad++; $display("FAIL reset_init: got %h expected %h", {q_valid, q}, 9'h000);
    end
    en = 1'b1; d_valid = 1'b1; d = 8'hAA;
    repeat (5) step();
    total++;
    if ({q_valid, q} !== 9'h1AA) begin
      bad++; $display("FAIL reset_fill: got %h expected %h", {q_valid, q}, 9'h1AA);
    end
    reset = 1'b1;
    step();
    total++;
    if ({q_valid, q} !== 9'h000) begin
      bad++; $display("FAIL reset_mid: got %h expected %h", {q_valid, q}, 9'h000);
    end
    total++;
    if ({q1_valid, q1} !== 9'h000) begin
      bad++; $display("FAIL reset_d1: got %h expected %h", {q1_valid, q1}, 9'h000);
    end
`ifdef DTYPE_PIPE_COUNT_EN
    total++;
    if (occ !== 3'd0) begin
      bad++; $display("FAIL reset_occ: got %0d expected 0", occ);
    end
`endif
    reset = 1'b0;
    repeat (3) step();
    total++;
    if (q_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release_early: got %b expected 0", q_valid);
    end
    step();
    total++;
    if ({q_valid, q} !== 9'h1AA) begin
      bad++; $display("FAIL reset_release: got %h expected %h", {q_valid, q}, 9'h1AA);
    end
  endtask

  task automatic test_latency();
    int exp_occ [12] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d_valid = (k < 8);
      d       = (k < 8) ? 8'(8'h11 + k) : 8'h00;
      step();
      total++;
      if (k >= 3 && k < 11) begin
        if ({q_valid, q} !== {1'b1, 8'(8'h11 + k - 3)}) begin
          bad++; $display("FAIL latency[%0d]: got %h expected %h", k, {q_valid, q}, {1'b1, 8'(8'h11 + k - 3)});
        end
      end else if (q_valid !== 1'b0) begin
        bad++; $display("FAIL latency_idle[%0d]: got %b expected 0", k, q_valid);
      end
`ifdef DTYPE_PIPE_COUNT_EN
      total++;
      if (occ !== 3'(exp_occ[k])) begin
        bad++; $display("FAIL latency_occ[%0d]: got %0d expected %0d", k, occ, exp_occ[k]);
      end
`endif
    end
  endtask

  task automatic test_stall();
    logic       st_en [13] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [7:0] st_d  [13] = '{8'h11, 8'h12, 8'hEE, 8'hEE, 8'hEE, 8'h13, 8'h14,
                               8'h15, 8'h16, 8'hEE, 8'hEE, 8'h17, 8'h18};
    logic [8:0] st_q  [13] = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h111,
                               9'h112, 9'h113, 9'h113, 9'h113, 9'h114, 9'h115};
    do_reset();
    d_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      en = st_en[k];
      d  = st_d[k];
      step();
      total++;
      if ({q_valid, q} !== st_q[k]) begin
        bad++; $display("FAIL stall[%0d]: got %h expected %h", k, {q_valid, q}, st_q[k]);
      end
    end
  endtask

  task automatic test_flush();
    logic exp_v [5] = '{0, 0, 0, 1, 0};
    do_reset();
    en = 1'b1; d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 8'(8'hA1 + k);
      step();
    end
    flush = 1'b1; d = 8'hA4;
    step();
    flush = 1'b0;
    total++;
    if (q_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got %b expected 0", q_valid);
    end
`ifdef DTYPE_PIPE_COUNT_EN
    total++;
    if (occ !== 3'd0) begin
      bad++; $display("FAIL flush_occ: got %0d expected 0", occ);
    end
`endif
    for (int k = 0; k < 5; k++) begin
      d_valid = (k == 0);
      d       = (k == 0) ? 8'hB5 : 8'h00;
      step();
      total++;
      if (q_valid !== exp_v[k]) begin
        bad++; $display("FAIL flush_after[%0d]: got %b expected %b", k, q_valid, exp_v[k]);
      end
      if (exp_v[k]) begin
        total++;
        if (q !== 8'hB5) begin
          bad++; $display("FAIL flush_word: got %h expected b5", q);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    logic exp_v;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d_valid = (k % 2 == 0);
      d       = 8'(8'h20 + k);
      step();
      if (k >= 3) begin
        exp_v = ((k - 3) % 2 == 0);
        total++;
        if (q_valid !== exp_v) begin
          bad++; $display("FAIL bubbles_v[%0d]: got %b expected %b", k, q_valid, exp_v);
        end
        if (exp_v) begin
          total++;
          if (q !== 8'(8'h20 + k - 3)) begin
            bad++; $display("FAIL bubbles_q[%0d]: got %h expected %h", k, q, 8'(8'h20 + k - 3));
          end
        end
`ifdef DTYPE_PIPE_COUNT_EN
        total++;
        if (occ !== 3'd2) begin
          bad++; $display("FAIL bubbles_occ[%0d]: got %0d expected 2", k, occ);
        end
`endif
      end
    end
  endtask

  task automatic test_depth1();
    logic       s_en [5] = '{1, 1, 0, 1, 1};
    logic       s_fl [5] = '{0, 0, 0, 1, 0};
    logic       s_dv [5] = '{1, 1, 1, 1, 0};
    logic [7:0] s_d  [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    logic [8:0] s_q  [5] = '{9'h1C1, 9'h1C2, 9'h1C2, 9'h0C4, 9'h0C5};
    logic       s_oc [5] = '{1, 1, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      en = s_en[k]; flush = s_fl[k]; d_valid = s_dv[k]; d = s_d[k];
      step();
      total++;
      if ({q1_valid, q1} !== s_q[k]) begin
        bad++; $display("FAIL depth1[%0d]: got %h expected %h", k, {q1_valid, q1}, s_q[k]);
      end
`ifdef DTYPE_PIPE_COUNT_EN
      total++;
      if (occ1 !== s_oc[k]) begin
        bad++; $display("FAIL depth1_occ[%0d]: got %0d expected %0d", k, occ1, s_oc[k]);
      end
`endif
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bubbles();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
